// File: rtl/mips_mem_pkg.sv
// Shared constants and types for the MIPS memory responder: I/O window map,
// STATUS bit positions and the address-decode select type.
package mips_mem_pkg;

  localparam logic [31:0] IO_BASE_DEF = 32'hFFFF_FF00;

  localparam logic [7:0] OFS_TX     = 8'h00;
  localparam logic [7:0] OFS_STATUS = 8'h04;
  localparam logic [7:0] OFS_CYCLES = 8'h08;
  localparam logic [7:0] OFS_COUNT  = 8'h0C;

  localparam int STAT_VALID = 0;
  localparam int STAT_EMPTY = 1;
  localparam int STAT_FULL  = 2;
  localparam int STAT_OVF   = 3;

  typedef enum logic [2:0] {
    SEL_RAM,
    SEL_TX,
    SEL_STATUS,
    SEL_CYCLES,
    SEL_COUNT,
    SEL_NONE
  } io_sel_e;

  // Maps a word offset inside the I/O window to its register select.
  function automatic io_sel_e io_sel_from_word(input logic [29:0] ofs_word);
    io_sel_e sel;
    sel = SEL_NONE;
    if (ofs_word == 30'(OFS_TX >> 2))          sel = SEL_TX;
    else if (ofs_word == 30'(OFS_STATUS >> 2)) sel = SEL_STATUS;
    else if (ofs_word == 30'(OFS_CYCLES >> 2)) sel = SEL_CYCLES;
    else if (ofs_word == 30'(OFS_COUNT >> 2))  sel = SEL_COUNT;
    return sel;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count. Push while full is accepted only
// when a pop frees the slot in the same cycle; pop while empty is ignored.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic [WIDTH-1:0]           din,
  input  logic                       pop,
  output logic [WIDTH-1:0]           dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign empty   = (count == '0);
  assign full    = (count == DEPTH_CNT);
  assign dout    = mem[rd_ptr];
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);

  always_ff @(posedge clk) begin
    if (reset && push_ok) mem[wr_ptr] <= din;
  end

  // Power-of-two depth lets the pointers wrap naturally.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/mips_mem_responder.sv
// Memory target for the multicycle MIPS core: unified RAM plus an I/O window
// with console TX FIFO, sticky status and a free-running cycle counter.
module mips_mem_responder
  import mips_mem_pkg::*;
#(
  parameter int          MEM_WORDS  = 64,
  parameter int          FIFO_DEPTH = 8,
  parameter logic [31:0] IO_BASE    = IO_BASE_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] adr,
  input  logic [31:0] writedata,
  input  logic        memwrite,
  output logic [31:0] readdata,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready
);

  localparam int          AW        = $clog2(MEM_WORDS);
  localparam int          CW        = $clog2(FIFO_DEPTH) + 1;
  localparam logic [29:0] MEM_LIMIT = 30'(MEM_WORDS);

  logic [31:0]   mem [MEM_WORDS];
  logic [29:0]   word;
  logic [29:0]   io_word;
  io_sel_e       sel;
  logic          ram_hit;
  logic [AW-1:0] ram_idx;
  logic          unused_bits;

  logic          tx_push;
  logic          tx_pop;
  logic          fifo_full;
  logic          fifo_empty;
  logic [CW-1:0] fifo_count;
  logic          overflow;
  logic [31:0]   cycles;
  logic [31:0]   status;

  // Decode on the full word address so no aliasing into the I/O window.
  assign word        = adr[31:2];
  assign io_word     = word - IO_BASE[31:2];
  assign unused_bits = ^adr[1:0];

  always_comb begin
    sel = SEL_RAM;
    if (word >= IO_BASE[31:2]) sel = io_sel_from_word(io_word);
  end

  assign ram_hit = (sel == SEL_RAM) && (word < MEM_LIMIT);
  assign ram_idx = word[AW-1:0];

  always_ff @(posedge clk) begin
    if (reset && memwrite && ram_hit) mem[ram_idx] <= writedata;
  end

  assign tx_push  = memwrite && (sel == SEL_TX);
  assign tx_pop   = tx_valid && tx_ready;
  assign tx_valid = !fifo_empty;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_tx_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (tx_push),
    .din   (writedata[7:0]),
    .pop   (tx_pop),
    .dout  (tx_data),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      overflow <= 1'b0;
    end else if (tx_push && fifo_full && !tx_pop) begin
      overflow <= 1'b1;
    end else if (memwrite && (sel == SEL_STATUS) && writedata[STAT_OVF]) begin
      overflow <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cycles <= '0;
    end else if (memwrite && (sel == SEL_CYCLES)) begin
      cycles <= writedata;
    end else begin
      cycles <= cycles + 32'd1;
    end
  end

  always_comb begin
    status             = '0;
    status[STAT_VALID] = tx_valid;
    status[STAT_EMPTY] = fifo_empty;
    status[STAT_FULL]  = fifo_full;
    status[STAT_OVF]   = overflow;
  end

  always_comb begin
    readdata = '0;
    case (sel)
      SEL_RAM:    if (ram_hit) readdata = mem[ram_idx];
      SEL_STATUS: readdata = status;
      SEL_CYCLES: readdata = cycles;
      SEL_COUNT:  readdata = 32'(fifo_count);
      default:    readdata = '0;
    endcase
  end

endmodule
